// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - shared constants, state encoding and R1 helper for the SD SPI responder
package sd_spi_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD16 = 6'd16;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;

  localparam logic [7:0]  TOKEN_START = 8'hFE;
  localparam logic [31:0] OCR         = 32'hC0FF8000;
  localparam int          BLOCK_BYTES = 512;

  typedef enum logic [2:0] {
    ST_CMD_WAIT,
    ST_CMD_RX,
    ST_NCR,
    ST_RESP,
    ST_GAP,
    ST_TOKEN,
    ST_DATA,
    ST_CRC
  } state_t;

  function automatic logic [7:0] r1_byte(input logic illegal, input logic idle);
    logic [7:0] r;
    r = 8'h00;
    r[R1_ILLEGAL] = illegal;
    r[R1_IDLE]    = idle;
    return r;
  endfunction

endpackage

// File: rtl/sd_spi_responder_if.sv
// rtl/sd_spi_responder_if.sv - SD SPI link, backing-memory and command-status bundle
interface sd_spi_responder_if #(
  parameter int ADDR_W = 32
);
  logic              sd_cs_n;
  logic              sd_sclk;
  logic              sd_mosi;
  logic              sd_miso;
  logic              sd_miso_oe;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              card_idle;
  logic              cmd_strobe;
  logic [5:0]        cmd_index;
  logic [31:0]       cmd_arg;

  modport master (
    output sd_cs_n, sd_sclk, sd_mosi, mem_rdata,
    input  sd_miso, sd_miso_oe, mem_rd_en, mem_addr, card_idle, cmd_strobe, cmd_index, cmd_arg
  );

  modport slave (
    input  sd_cs_n, sd_sclk, sd_mosi, mem_rdata,
    output sd_miso, sd_miso_oe, mem_rd_en, mem_addr, card_idle, cmd_strobe, cmd_index, cmd_arg
  );
endinterface

// File: rtl/spi_slave_byte_if.sv
// rtl/spi_slave_byte_if.sv - oversampled SPI mode-0 byte engine (sync, edge detect, shift, handshake)
module spi_slave_byte_if (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  input  logic [7:0] tx_byte_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       cs_n_sync_o,
  output logic       miso_o,
  output logic       miso_oe_o
);

  logic [1:0] sclk_s_q, cs_s_q, mosi_s_q;
  logic       sclk_prev_q, cs_prev_q;
  logic [7:0] rx_q, tx_q;
  logic [2:0] cnt_q;
  logic       miso_q, oe_q;
  logic       rise, fall;

  assign cs_n_sync_o = cs_s_q[1];
  assign rise        = sclk_s_q[1] & ~sclk_prev_q & ~cs_s_q[1];
  assign fall        = ~sclk_s_q[1] & sclk_prev_q & ~cs_s_q[1];
  assign rx_valid_o  = rise && (cnt_q == 3'd7);
  assign rx_byte_o   = {rx_q[6:0], mosi_s_q[1]};
  assign miso_o      = miso_q;
  assign miso_oe_o   = oe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s_q    <= 2'b00;
      cs_s_q      <= 2'b11;
      mosi_s_q    <= 2'b11;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      rx_q        <= 8'h00;
      tx_q        <= 8'hFF;
      cnt_q       <= 3'd0;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
    end else begin
      sclk_s_q    <= {sclk_s_q[0], sclk_i};
      cs_s_q      <= {cs_s_q[0], cs_n_i};
      mosi_s_q    <= {mosi_s_q[0], mosi_i};
      sclk_prev_q <= sclk_s_q[1];
      cs_prev_q   <= cs_s_q[1];
      if (cs_s_q[1]) begin
        oe_q   <= 1'b0;
        miso_q <= 1'b1;
        cnt_q  <= 3'd0;
        tx_q   <= 8'hFF;
      end else begin
        if (cs_prev_q) begin
          tx_q <= 8'hFF;
          oe_q <= 1'b1;
        end
        if (rise) begin
          rx_q  <= rx_byte_o;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) tx_q <= tx_byte_i;
        end
        // The byte loaded on the 8th rise shows its MSB on the very next fall.
        if (fall) begin
          miso_q <= tx_q[7];
          tx_q   <= {tx_q[6:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SPI-mode SD card responder: command framing, R1/R3/R7, CMD17 block reads
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int NAC_BYTES    = 1,
  parameter int ACMD41_COUNT = 2
) (
  input logic              clk,
  input logic              rst,
  sd_spi_responder_if.slave bus
);

  logic              rx_valid, cs_n_sync, miso, miso_oe;
  logic [7:0]        rx_byte, tx_byte;
  state_t            state_q, state_d;
  logic [8:0]        cnt_q, cnt_d, rd_off;
  logic [5:0]        idx_q, idx_d, cmd_index_q, cmd_index_d;
  logic [31:0]       arg_q, arg_d, cmd_arg_q, cmd_arg_d;
  logic              strobe_q, strobe_d, idle_q, idle_d, app_q, app_d, read_q, read_d;
  logic              idle_n, rd_en_q, rd_en_d;
  logic [3:0]        a41_q, a41_d, a41_n;
  logic [39:0]       resp_q, resp_d;
  logic [2:0]        last_q, last_d, lat_q;
  logic [7:0]        data_q;
  logic [ADDR_W-1:0] addr_q, rd_addr;

  spi_slave_byte_if u_byte (
    .clk        (clk),
    .rst        (rst),
    .sclk_i     (bus.sd_sclk),
    .cs_n_i     (bus.sd_cs_n),
    .mosi_i     (bus.sd_mosi),
    .tx_byte_i  (tx_byte),
    .rx_valid_o (rx_valid),
    .rx_byte_o  (rx_byte),
    .cs_n_sync_o(cs_n_sync),
    .miso_o     (miso),
    .miso_oe_o  (miso_oe)
  );

  assign rd_addr = ADDR_W'({cmd_arg_q, 9'b0}) + ADDR_W'(rd_off);

  // tx_byte is the first byte of whichever phase the completed host byte moves us into.
  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  idx_d = idx_q;  arg_d = arg_q;
    cmd_index_d = cmd_index_q;  cmd_arg_d = cmd_arg_q;  strobe_d = 1'b0;
    idle_d = idle_q;  app_d = app_q;  a41_d = a41_q;  resp_d = resp_q;
    last_d = last_q;  read_d = read_q;  rd_en_d = 1'b0;  rd_off = 9'd0;
    tx_byte = 8'hFF;  a41_n = a41_q;  idle_n = idle_q;
    if (cs_n_sync) begin
      state_d = ST_CMD_WAIT;
      cnt_d   = 9'd0;
    end else if (rx_valid) begin
      case (state_q)
        ST_CMD_WAIT: if (rx_byte[7:6] == 2'b01) begin
          idx_d = rx_byte[5:0];  cnt_d = 9'd0;  state_d = ST_CMD_RX;
        end
        ST_CMD_RX: if (cnt_q != 9'd4) begin
          arg_d = {arg_q[23:0], rx_byte};  cnt_d = cnt_q + 9'd1;
        end else begin
          strobe_d = 1'b1;  cmd_index_d = idx_q;  cmd_arg_d = arg_q;
          app_d = 1'b0;  last_d = 3'd0;  read_d = 1'b0;  state_d = ST_NCR;
          resp_d = {r1_byte(1'b0, idle_q), 32'h0};
          case (idx_q)
            CMD0: begin
              idle_d = 1'b1;  a41_d = 4'd0;  resp_d = {r1_byte(1'b0, 1'b1), 32'h0};
            end
            CMD8: begin
              resp_d = {r1_byte(1'b0, idle_q), 16'h0, 4'h0, arg_q[11:8], arg_q[7:0]};
              last_d = 3'd4;
            end
            CMD55: app_d = 1'b1;
            CMD41: if (app_q) begin
              a41_n  = (a41_q == 4'(ACMD41_COUNT)) ? a41_q : a41_q + 4'd1;
              idle_n = (a41_n == 4'(ACMD41_COUNT)) ? 1'b0 : idle_q;
              a41_d  = a41_n;  idle_d = idle_n;
              resp_d = {r1_byte(1'b0, idle_n), 32'h0};
            end else begin
              resp_d = {r1_byte(1'b1, idle_q), 32'h0};
            end
            CMD58: begin
              resp_d = {r1_byte(1'b0, idle_q), OCR};  last_d = 3'd4;
            end
            CMD16: ;
            CMD17: if (idle_q) resp_d = {r1_byte(1'b1, 1'b1), 32'h0};
                   else read_d = 1'b1;
            default: resp_d = {r1_byte(1'b1, idle_q), 32'h0};
          endcase
        end
        ST_NCR: begin
          state_d = ST_RESP;  cnt_d = 9'd0;  tx_byte = resp_q[39:32];
        end
        ST_RESP: if (cnt_q == {6'd0, last_q}) begin
          cnt_d = 9'd0;
          if (read_q) begin
            state_d = ST_GAP;  rd_en_d = 1'b1;
          end else begin
            state_d = ST_CMD_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;  tx_byte = resp_q[31:24];  resp_d = {resp_q[31:0], 8'h00};
        end
        ST_GAP: if (cnt_q == 9'(NAC_BYTES - 1)) begin
          state_d = ST_TOKEN;  tx_byte = TOKEN_START;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
        ST_TOKEN: begin
          state_d = ST_DATA;  cnt_d = 9'd0;  tx_byte = data_q;  rd_en_d = 1'b1;  rd_off = 9'd1;
        end
        ST_DATA: if (cnt_q == 9'(BLOCK_BYTES - 1)) begin
          state_d = ST_CRC;  cnt_d = 9'd0;
        end else begin
          cnt_d = cnt_q + 9'd1;  tx_byte = data_q;
          if (cnt_q < 9'(BLOCK_BYTES - 2)) begin
            rd_en_d = 1'b1;  rd_off = cnt_q + 9'd2;
          end
        end
        ST_CRC: if (cnt_q == 9'd1) state_d = ST_CMD_WAIT;
                else cnt_d = cnt_q + 9'd1;
        default: state_d = ST_CMD_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CMD_WAIT;  cnt_q <= 9'd0;  idx_q <= 6'd0;  arg_q <= 32'h0;
      cmd_index_q <= 6'd0;  cmd_arg_q <= 32'h0;  strobe_q <= 1'b0;
      idle_q <= 1'b1;  app_q <= 1'b0;  a41_q <= 4'd0;  resp_q <= 40'h0;
      last_q <= 3'd0;  read_q <= 1'b0;  rd_en_q <= 1'b0;  addr_q <= '0;
      lat_q <= 3'd0;  data_q <= 8'hFF;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  idx_q <= idx_d;  arg_q <= arg_d;
      cmd_index_q <= cmd_index_d;  cmd_arg_q <= cmd_arg_d;  strobe_q <= strobe_d;
      idle_q <= idle_d;  app_q <= app_d;  a41_q <= a41_d;  resp_q <= resp_d;
      last_q <= last_d;  read_q <= read_d;  rd_en_q <= rd_en_d;
      if (rd_en_d) addr_q <= rd_addr;
      // Reads are a full byte time apart, so a single latency countdown suffices.
      if (rd_en_q) lat_q <= 3'(MEM_LAT);
      else if (lat_q != 3'd0) lat_q <= lat_q - 3'd1;
      if (lat_q == 3'd1) data_q <= bus.mem_rdata;
    end
  end

  assign bus.sd_miso    = miso;
  assign bus.sd_miso_oe = miso_oe;
  assign bus.mem_rd_en  = rd_en_q;
  assign bus.mem_addr   = addr_q;
  assign bus.card_idle  = idle_q;
  assign bus.cmd_strobe = strobe_q;
  assign bus.cmd_index  = cmd_index_q;
  assign bus.cmd_arg    = cmd_arg_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - directed host-side bench for sd_spi_responder
module tb_sd_spi_responder;

  logic clk, rst;
  sd_spi_responder_if #(.ADDR_W(32)) bus ();

  sd_spi_responder #(
    .ADDR_W(32), .MEM_LAT(1), .NAC_BYTES(1), .ACMD41_COUNT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          strobe_cnt = 0;
  logic [5:0]  last_idx = 6'h3F;
  logic [31:0] rd_log [$];
  logic [7:0]  ncr, cmd_and;
  logic [7:0]  rsp [5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= bus.mem_addr[7:0];

  always @(negedge clk) begin
    if (bus.cmd_strobe) begin
      strobe_cnt++;
      last_idx = bus.cmd_index;
    end
    if (bus.mem_rd_en) rd_log.push_back(bus.mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] t, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      bus.sd_mosi = t[i];
      #50;
      r[i] = bus.sd_miso;
      bus.sd_sclk = 1'b1;
      #50;
      bus.sd_sclk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] a, input logic [7:0] crc);
    logic [7:0] b, r;
    cmd_and = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0:       b = {2'b01, idx};
        1:       b = a[31:24];
        2:       b = a[23:16];
        3:       b = a[15:8];
        4:       b = a[7:0];
        default: b = crc;
      endcase
      xfer(b, r);
      cmd_and &= r;
    end
  endtask

  task automatic get_resp(input int n);
    xfer(8'hFF, ncr);
    for (int k = 0; k < n; k++) xfer(8'hFF, rsp[k]);
  endtask

  task automatic chk_resp(input string tag, input int n, input logic [39:0] exp);
    chk({tag, ".ncr"}, ncr, 8'hFF);
    for (int k = 0; k < n; k++) chk($sformatf("%s[%0d]", tag, k), rsp[k], exp[39-8*k -: 8]);
  endtask

  initial begin
    logic [7:0] r;
    int         data_err, fe_seen;
    rst = 1'b1;
    bus.sd_cs_n = 1'b1;
    bus.sd_sclk = 1'b0;
    bus.sd_mosi = 1'b1;
    #23 rst = 1'b0;
    #20;
    chk("rst.miso", bus.sd_miso, 1);
    chk("rst.miso_oe", bus.sd_miso_oe, 0);
    chk("rst.mem_rd_en", bus.mem_rd_en, 0);
    chk("rst.mem_addr", bus.mem_addr, 0);
    chk("rst.card_idle", bus.card_idle, 1);
    chk("rst.cmd_strobe", bus.cmd_strobe, 0);
    chk("rst.cmd_index", bus.cmd_index, 0);
    chk("rst.cmd_arg", bus.cmd_arg, 0);

    bus.sd_cs_n = 1'b0;
    #100;
    chk("cs.miso_oe", bus.sd_miso_oe, 1);

    send_cmd(6'd0, 32'h0, 8'h95);
    get_resp(1);
    chk_resp("cmd0", 1, {8'h01, 32'h0});
    chk("cmd0.strobes", strobe_cnt, 1);
    chk("cmd0.index", last_idx, 0);

    send_cmd(6'd17, 32'd5, 8'h01);
    get_resp(1);
    chk_resp("cmd17_idle", 1, {8'h05, 32'h0});
    fe_seen = 0;
    for (int k = 0; k < 20; k++) begin
      xfer(8'hFF, r);
      if (r == 8'hFE) fe_seen++;
    end
    chk("cmd17_idle.no_token", fe_seen, 0);
    chk("cmd17_idle.no_reads", rd_log.size(), 0);

    send_cmd(6'd8, 32'h000001AA, 8'h87);
    get_resp(5);
    chk_resp("cmd8", 5, 40'h01_00_00_01_AA);
    chk("cmd8.arg", bus.cmd_arg, 32'h1AA);
    chk("cmd8.index", bus.cmd_index, 8);

    send_cmd(6'd55, 32'h0, 8'h01);  get_resp(1);  chk_resp("cmd55a", 1, {8'h01, 32'h0});
    send_cmd(6'd41, 32'h40000000, 8'h01);  get_resp(1);  chk_resp("acmd41a", 1, {8'h01, 32'h0});
    chk("acmd41a.idle", bus.card_idle, 1);
    send_cmd(6'd55, 32'h0, 8'h01);  get_resp(1);  chk_resp("cmd55b", 1, {8'h01, 32'h0});
    send_cmd(6'd41, 32'h40000000, 8'h01);  get_resp(1);  chk_resp("acmd41b", 1, {8'h00, 32'h0});
    chk("acmd41b.idle", bus.card_idle, 0);

    send_cmd(6'd58, 32'h0, 8'h01);
    get_resp(5);
    chk_resp("cmd58", 5, 40'h00_C0_FF_80_00);

    send_cmd(6'd9, 32'h0, 8'h01);
    get_resp(1);
    chk_resp("cmd9", 1, {8'h04, 32'h0});

    rd_log.delete();
    send_cmd(6'd17, 32'd5, 8'h01);
    get_resp(1);
    chk_resp("cmd17", 1, {8'h00, 32'h0});
    xfer(8'hFF, r);  chk("cmd17.nac", r, 8'hFF);
    xfer(8'hFF, r);  chk("cmd17.token", r, 8'hFE);
    data_err = 0;
    for (int n = 0; n < 512; n++) begin
      xfer(8'hFF, r);
      if (r !== n[7:0]) data_err++;
    end
    chk("cmd17.data_errors", data_err, 0);
    xfer(8'hFF, r);  chk("cmd17.crc0", r, 8'hFF);
    xfer(8'hFF, r);  chk("cmd17.crc1", r, 8'hFF);
    chk("cmd17.reads", rd_log.size(), 512);
    if (rd_log.size() == 512) begin
      chk("cmd17.first_addr", rd_log[0], 32'hA00);
      chk("cmd17.last_addr", rd_log[511], 32'hBFF);
    end

    send_cmd(6'd17, 32'd5, 8'h01);
    get_resp(1);
    chk_resp("abort17", 1, {8'h00, 32'h0});
    xfer(8'hFF, r);
    xfer(8'hFF, r);  chk("abort17.token", r, 8'hFE);
    data_err = 0;
    for (int n = 0; n < 100; n++) begin
      xfer(8'hFF, r);
      if (r !== n[7:0]) data_err++;
    end
    chk("abort17.data_errors", data_err, 0);
    bus.sd_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort.miso_oe", bus.sd_miso_oe, 0);
    chk("abort.miso", bus.sd_miso, 1);
    #200;
    bus.sd_cs_n = 1'b0;
    #100;
    send_cmd(6'd0, 32'h0, 8'h95);
    chk("reassert.cmd_bytes", cmd_and, 8'hFF);
    get_resp(1);
    chk_resp("reassert.cmd0", 1, {8'h01, 32'h0});
    fe_seen = 0;
    for (int k = 0; k < 4; k++) begin
      xfer(8'hFF, r);
      if (r != 8'hFF) fe_seen++;
    end
    chk("reassert.quiet", fe_seen, 0);
    chk("reassert.idle", bus.card_idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- SPI-mode SD card responder: the card-side end of the DivMMC SD link (ports E7/EB host, SPI mode 0, MSB first, host clocks 0xFF while reading).
- Oversamples host SCLK/CS/MOSI on its own faster clock, frames 6-byte commands, and returns R1/R3/R7 responses.
- Serves single-block reads (CMD17) from a synchronous byte-wide backing memory.
- Used as the SD model in system benches and as a card emulator on the CPLD/FPGA side.

Parameters:
- ADDR_W, 32, backing memory byte address width; mem_addr = {arg, 9'b0} + offset, truncated to ADDR_W.
- MEM_LAT, 1, cycles from mem_rd_en to mem_rdata valid; legal range 1..4.
- NAC_BYTES, 1, number of 0xFF bytes between the CMD17 R1 and the 0xFE token; range 1..8.
- ACMD41_COUNT, 2, number of ACMD41s needed to leave idle; range 1..15.

Ports:
- clk  in  1  responder clock; must be at least 4x host SCLK.
- rst  in  1  asynchronous reset, active high.
- sd_cs_n  in  1  host chip select, active low.
- sd_sclk  in  1  host SPI clock.
- sd_mosi  in  1  host data out.
- sd_miso  out  1  card data out; 1 when not driven.
- sd_miso_oe  out  1  tristate enable for sd_miso.
- mem_rd_en  out  1  one-cycle read strobe to backing memory.
- mem_addr  out  ADDR_W  byte address of the read.
- mem_rdata  in  8  read data, valid MEM_LAT cycles after mem_rd_en.
- card_idle  out  1  card in idle state (R1 bit0).
- cmd_strobe  out  1  one-cycle pulse when a 6-byte command completes.
- cmd_index  out  6  index of the last command.
- cmd_arg  out  32  argument of the last command.

Behaviour:
- Reset values:
  - sd_miso=1, sd_miso_oe=0, mem_rd_en=0, mem_addr=0.
  - card_idle=1, cmd_strobe=0, cmd_index=0, cmd_arg=0.
  - app_cmd=0, acmd41 counter=0, FSM=CMD_WAIT.
- Input sync:
  - 2-FF synchronisers on sclk, cs_n and mosi; edge detect on synchronised sclk.
  - Edges are ignored while synchronised cs_n=1.
- Bit shifting:
  - Rising edge samples mosi into rx shift and increments bit count 0..7.
  - Falling edge shifts tx; sd_miso = tx[7].
  - On the 8th rising edge: rx byte complete (rx_valid pulse), tx loaded with the next byte, count returns to 0. The new MSB appears at the next falling edge.
  - On cs_n falling: tx=0xFF, oe=1.
  - On cs_n high: oe=0, miso=1, bit count cleared, FSM to CMD_WAIT (aborts any phase). card_idle, app_cmd and the ACMD41 counter are retained.
- FSM, one transition per completed byte:
  - CMD_WAIT: tx=0xFF. A byte with [7:6]=01 captures the index and goes to CMD_RX. Any other byte stays.
  - CMD_RX: collects 4 argument bytes plus the CRC byte. CRC is ignored. On the 5th byte: cmd_strobe, cmd_index/cmd_arg update, response decoded, go to NCR.
  - NCR: one 0xFF byte, then RESP.
  - RESP: sends 1 or 5 response bytes.
    - After a CMD17 with R1=0x00, go to GAP.
    - Otherwise go to CMD_WAIT.
  - GAP: NAC_BYTES of 0xFF, then TOKEN. mem read of offset 0 is issued at GAP entry.
  - TOKEN: sends 0xFE, then DATA.
  - DATA: sends 512 bytes, offset 0..511. The read for offset n+1 is issued when byte n is loaded, so data is ready well before the byte boundary.
  - CRC: sends 0xFF, 0xFF, then CMD_WAIT.
  - Host bytes received outside CMD_WAIT/CMD_RX are discarded, including command bytes.
- Command decode (R1 = {7'b0, card_idle} unless stated; app_cmd clears after any command except CMD55):
  - CMD0: card_idle=1, counter=0, app_cmd=0. R1 = 0x01.
  - CMD8: R7 = R1, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0].
  - CMD55: app_cmd=1. Responds R1.
  - CMD41 with app_cmd: counter increments; when it reaches ACMD41_COUNT, card_idle=0. R1 reflects the updated idle bit.
  - CMD58: R3 = R1, 0xC0, 0xFF, 0x80, 0x00 (CCS=1, block addressing).
  - CMD16: responds R1; the argument is ignored (block length fixed at 512).
  - CMD17: if card_idle=1, R1 = 0x05 and no data phase. Otherwise R1 = 0x00 and the block at LBA arg is read.
  - Any other command, or CMD41 without app_cmd: R1 = {5'b0, 1'b1, 1'b0, card_idle} (illegal bit set).
- Simultaneous events: rst dominates. A cs_n rise in the same cycle as a byte completion aborts; the byte is discarded.

Decomposition:
- Package sd_spi_pkg:
  - command indices CMD0/8/16/17/41/55/58;
  - R1 bit positions;
  - TOKEN_START=8'hFE;
  - OCR constant 32'hC0FF8000;
  - BLOCK_BYTES=512;
  - FSM state enum.
- Sub-module spi_slave_byte_if: synchronisers, edge detect, rx/tx shift registers, bit counter, rx_valid/tx_load handshake. The top-level FSM sits above it.

Test Plan:
- cs_n low, host sends 40 00 00 00 00 95 then clocks 0xFF → host reads FF (NCR) then 0x01; cmd_strobe pulses with cmd_index=0.
- CMD8 arg 0x000001AA → response bytes 01 00 00 01 AA.
- ACMD41_COUNT=2, (CMD55, ACMD41 arg 0x40000000) twice → R1 0x01, 0x01, 0x01, 0x00; card_idle falls; then CMD58 → 00 C0 FF 80 00.
- CMD17 arg 5 with memory filled as byte = addr[7:0] → R1 00, NAC FF, FE, 512 bytes reading 0x00..0xFF twice from mem_addr 0xA00..0xBFF, then FF FF.
- CMD9 after init → 0x04; CMD17 before init → 0x05 with no FE token ever seen.
- cs_n raised after data byte 100 of a CMD17 → miso_oe=0 within 3 clk; reassert plus CMD0 → 0x01 response, no stale data.
